// File: rtl/prog_launch_sched_if.sv
// rtl/prog_launch_sched_if.sv - board-side request / core-side launch signals of prog_launch_sched
//
// Purpose: bundles the button requests, core handshake and status outputs of
// the launch scheduler so the board wrapper and bench connect with one name.
//
// Signals:
//   btn_req           4      raw level requests: [0]=fib [1]=sort [2]=save [3]=load
//   cpu_done          1      core finished current program
//   program_selector  SEL_W  0 idle; 1..4 program code while arming
//   cpu_start         1      one-cycle pulse on the first arming cycle
//   busy              1      launch in progress (arming or running)
//   pending           4      queued, not-yet-granted requests
//   timeout           1      watchdog fired; sticky until next grant
//
// Modports:
//   master  board / core side: drives requests and cpu_done
//   slave   scheduler side: drives selector and status

interface prog_launch_sched_if #(
  parameter int SEL_W = 32
);
  logic [3:0]       btn_req;
  logic             cpu_done;
  logic [SEL_W-1:0] program_selector;
  logic             cpu_start;
  logic             busy;
  logic [3:0]       pending;
  logic             timeout;

  modport master (
    output btn_req,
    output cpu_done,
    input  program_selector,
    input  cpu_start,
    input  busy,
    input  pending,
    input  timeout
  );

  modport slave (
    input  btn_req,
    input  cpu_done,
    output program_selector,
    output cpu_start,
    output busy,
    output pending,
    output timeout
  );
endinterface

// File: rtl/prog_launch_sched.sv
// rtl/prog_launch_sched.sv - fixed-priority program launch scheduler for the RISC core
//
// Purpose: synchronises and edge-detects four front-panel buttons, queues one
// pending launch per program, grants the lowest pending index, holds the
// core's program_selector non-zero for HOLD_CYCLES so the boot copy completes,
// then waits for cpu_done before the next launch.
//
// Ports:
//   clock    in  system clock, all state on rising edge
//   reset_n  in  asynchronous active-low reset
//   bus      prog_launch_sched_if.slave (btn_req, cpu_done in; program_selector,
//            cpu_start, busy, pending, timeout out)
//
// Parameters:
//   HOLD_CYCLES     cycles the selector is held non-zero per launch (>= 1)
//   SEL_W           width of program_selector
//   TIMEOUT_CYCLES  RUN-state watchdog limit
//
// Build option: define PROG_WATCHDOG_EN to enable the RUN-state watchdog;
// otherwise RUN waits indefinitely for cpu_done and timeout is tied low.

module prog_launch_sched #(
  parameter int HOLD_CYCLES    = 4,
  parameter int SEL_W          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clock,
  input  logic                reset_n,
  prog_launch_sched_if.slave  bus
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t            state_q, state_d;

  logic [3:0]        sync1_q, sync2_q, prev_q, edge_q;
  logic [3:0]        pending_q;
  logic [1:0]        grant_q;
  logic [1:0]        grant_idx;
  logic [3:0]        grant_mask;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              arm_first_q;
  logic              grant_en;

  logic [SEL_W-1:0]  sel_c;
  logic              start_c;
  logic              busy_c;

`ifdef PROG_WATCHDOG_EN
  localparam int RUN_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [RUN_W-1:0]  run_cnt_q;
  logic              timeout_q;
  logic              expire;
`else
  wire unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Lowest set pending bit wins: fib > sort > save > load.
  always_comb begin
    grant_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending_q[i]) grant_idx = 2'(i);
    end
  end

  assign grant_mask = grant_en ? (4'b0001 << grant_idx) : 4'b0000;

  // Input path: two-flop synchroniser, prev flop, registered rising edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= bus.btn_req;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edge_q  <= sync2_q & ~prev_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state and outputs.
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    sel_c    = '0;
    start_c  = 1'b0;
    busy_c   = 1'b0;
`ifdef PROG_WATCHDOG_EN
    expire   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          grant_en = 1'b1;
          state_d  = S_ARM;
        end
      end
      S_ARM: begin
        busy_c  = 1'b1;
        sel_c   = SEL_W'({1'b0, grant_q} + 3'd1);
        start_c = arm_first_q;
        if (hold_cnt_q == '0) state_d = S_RUN;
      end
      S_RUN: begin
        busy_c = 1'b1;
        // cpu_done is checked first so a completion on the expiry edge wins.
        if (bus.cpu_done) begin
          state_d = S_IDLE;
        end
`ifdef PROG_WATCHDOG_EN
        else if (run_cnt_q == RUN_W'(TIMEOUT_CYCLES - 1)) begin
          expire  = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Launch datapath: queue, grant latch, hold counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_q   <= '0;
      grant_q     <= '0;
      hold_cnt_q  <= '0;
      arm_first_q <= 1'b0;
    end else begin
      // A new edge on the bit being granted re-queues it in the same cycle.
      pending_q <= (pending_q & ~grant_mask) | edge_q;
      if (grant_en) begin
        grant_q     <= grant_idx;
        hold_cnt_q  <= HOLD_W'(HOLD_CYCLES - 1);
        arm_first_q <= 1'b1;
      end else begin
        arm_first_q <= 1'b0;
        if (state_q == S_ARM && hold_cnt_q != '0)
          hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
      end
    end
  end

`ifdef PROG_WATCHDOG_EN
  // RUN cycle counter starts at 0 on the first RUN cycle; timeout is sticky
  // until the next grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      run_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == S_RUN) run_cnt_q <= run_cnt_q + RUN_W'(1);
      else                  run_cnt_q <= '0;
      if (grant_en)    timeout_q <= 1'b0;
      else if (expire) timeout_q <= 1'b1;
    end
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.program_selector = sel_c;
  assign bus.cpu_start        = start_c;
  assign bus.busy             = busy_c;
  assign bus.pending          = pending_q;

endmodule

// File: tb/tb_prog_launch_sched.sv
// tb/tb_prog_launch_sched.sv - self-checking bench for prog_launch_sched

module tb_prog_launch_sched;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  prog_launch_sched_if #(.SEL_W(32)) bus();

  prog_launch_sched #(
    .HOLD_CYCLES    (4),
    .SEL_W          (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  btn;
    logic        done;
    logic [31:0] sel;
    logic        start;
    logic        busy;
    logic [3:0]  pend;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [3:0] btn, input logic done, input logic [31:0] sel,
                              input logic start, input logic busy, input logic [3:0] pend);
    vec_t v;
    v.btn = btn; v.done = done; v.sel = sel; v.start = start; v.busy = busy; v.pend = pend;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) until the first RUN cycle: busy with a zero selector.
  task automatic wait_run(input string name);
    bit found;
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      tick();
      if (bus.busy && bus.program_selector == 0) found = 1;
    end
    check({name, "_reached_run"}, {31'd0, found}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int starts;
    int sel_cycles;
    int busy_cycles;
    bit seen;

    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.btn_req  = 4'b0;
    bus.cpu_done = 1'b0;

    // btn, done, sel, start, busy, pending
    // Test 1: fib pressed two cycles
    add(4'h1,0,0,0,0,4'h0); add(4'h1,0,0,0,0,4'h0); add(4'h0,0,0,0,0,4'h0); add(4'h0,0,0,0,0,4'h1);
    add(4'h0,0,1,1,1,4'h0); add(4'h0,0,1,0,1,4'h0); add(4'h0,0,1,0,1,4'h0); add(4'h0,0,1,0,1,4'h0);
    add(4'h0,0,0,0,1,4'h0); add(4'h0,1,0,0,0,4'h0); add(4'h0,0,0,0,0,4'h0);
    // Test 2: sort and load rise together
    add(4'hA,0,0,0,0,4'h0); add(4'hA,0,0,0,0,4'h0); add(4'hA,0,0,0,0,4'h0); add(4'hA,0,0,0,0,4'hA);
    add(4'hA,0,2,1,1,4'h8); add(4'hA,0,2,0,1,4'h8); add(4'hA,0,2,0,1,4'h8); add(4'hA,0,2,0,1,4'h8);
    add(4'hA,0,0,0,1,4'h8); add(4'h0,1,0,0,0,4'h8);
    add(4'h0,0,4,1,1,4'h0); add(4'h0,0,4,0,1,4'h0); add(4'h0,0,4,0,1,4'h0); add(4'h0,0,4,0,1,4'h0);
    add(4'h0,0,0,0,1,4'h0); add(4'h0,1,0,0,0,4'h0); add(4'h0,0,0,0,0,4'h0);
    // Test 3: fib launch, save pressed twice during RUN
    add(4'h1,0,0,0,0,4'h0); add(4'h0,0,0,0,0,4'h0); add(4'h0,0,0,0,0,4'h0); add(4'h0,0,0,0,0,4'h1);
    add(4'h0,0,1,1,1,4'h0); add(4'h0,0,1,0,1,4'h0); add(4'h0,0,1,0,1,4'h0); add(4'h0,0,1,0,1,4'h0);
    add(4'h0,0,0,0,1,4'h0); add(4'h4,0,0,0,1,4'h0); add(4'h0,0,0,0,1,4'h0); add(4'h4,0,0,0,1,4'h0);
    add(4'h0,0,0,0,1,4'h4); add(4'h0,0,0,0,1,4'h4); add(4'h0,0,0,0,1,4'h4); add(4'h0,1,0,0,0,4'h4);
    add(4'h0,0,3,1,1,4'h0); add(4'h0,0,3,0,1,4'h0); add(4'h0,0,3,0,1,4'h0); add(4'h0,0,3,0,1,4'h0);
    add(4'h0,0,0,0,1,4'h0); add(4'h0,1,0,0,0,4'h0); add(4'h0,0,0,0,0,4'h0); add(4'h0,0,0,0,0,4'h0);

    // Reset state
    tick(); tick();
    check("rst_sel",     bus.program_selector, 32'd0);
    check("rst_start",   {31'd0, bus.cpu_start}, 32'd0);
    check("rst_busy",    {31'd0, bus.busy}, 32'd0);
    check("rst_pending", {28'd0, bus.pending}, 32'd0);
    check("rst_timeout", {31'd0, bus.timeout}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.btn_req  = vecs[i].btn;
      bus.cpu_done = vecs[i].done;
      tick();
      check($sformatf("row%0d_sel", i),   bus.program_selector, vecs[i].sel);
      check($sformatf("row%0d_start", i), {31'd0, bus.cpu_start}, {31'd0, vecs[i].start});
      check($sformatf("row%0d_busy", i),  {31'd0, bus.busy}, {31'd0, vecs[i].busy});
      check($sformatf("row%0d_pend", i),  {28'd0, bus.pending}, {28'd0, vecs[i].pend});
    end
    bus.btn_req  = 4'h0;
    bus.cpu_done = 1'b0;

    // Grant-clear and a new edge on the same bit in one cycle keep the bit set.
    bus.btn_req = 4'h1; tick(); bus.btn_req = 4'h0;
    wait_run("coll");
    bus.btn_req = 4'h4; tick(); bus.btn_req = 4'h0;
    repeat (4) tick();
    check("coll_queued", {28'd0, bus.pending}, 32'h4);
    bus.btn_req = 4'h4; tick();
    bus.btn_req = 4'h0; tick();
    bus.cpu_done = 1'b1; tick();
    check("coll_idle_busy", {31'd0, bus.busy}, 32'd0);
    bus.cpu_done = 1'b0; tick();
    check("coll_grant_sel", bus.program_selector, 32'd3);
    check("coll_requeued",  {28'd0, bus.pending}, 32'h4);
    bus.cpu_done = 1'b1;
    starts = 0;
    repeat (12) begin
      tick();
      if (bus.cpu_start) starts++;
    end
    bus.cpu_done = 1'b0;
    check("coll_second_launch", starts, 1);
    check("coll_drained", {28'd0, bus.pending}, 32'h0);

    // Test 4: held button launches once.
    bus.cpu_done = 1'b1;
    bus.btn_req  = 4'h1;
    starts = 0; sel_cycles = 0;
    repeat (100) begin
      tick();
      if (bus.cpu_start) starts++;
      if (bus.program_selector == 32'd1) sel_cycles++;
    end
    bus.btn_req = 4'h0;
    repeat (20) begin
      tick();
      if (bus.cpu_start) starts++;
      if (bus.program_selector == 32'd1) sel_cycles++;
    end
    bus.cpu_done = 1'b0;
    check("held_starts", starts, 1);
    check("held_sel_cycles", sel_cycles, 4);
    check("held_busy_end", {31'd0, bus.busy}, 32'd0);

    // Test 5: reset during ARM.
    bus.btn_req = 4'hA; tick(); bus.btn_req = 4'h0;
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (bus.program_selector != 0) seen = 1;
    end
    check("arm_reached", {31'd0, seen}, 32'd1);
    check("arm_sel", bus.program_selector, 32'd2);
    check("arm_pending", {28'd0, bus.pending}, 32'h8);
    reset_n = 1'b0;
    #1;
    check("arst_sel",     bus.program_selector, 32'd0);
    check("arst_busy",    {31'd0, bus.busy}, 32'd0);
    check("arst_pending", {28'd0, bus.pending}, 32'd0);
    check("arst_start",   {31'd0, bus.cpu_start}, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    busy_cycles = 0;
    repeat (20) begin
      tick();
      if (bus.busy) busy_cycles++;
    end
    check("post_rst_no_launch", busy_cycles, 0);

    // Test 6: cpu_done never arrives.
    bus.btn_req = 4'h1; tick(); bus.btn_req = 4'h0;
    wait_run("wd");
    repeat (15) tick();
    check("wd_busy_before", {31'd0, bus.busy}, 32'd1);
    tick();
`ifdef PROG_WATCHDOG_EN
    check("wd_busy_after", {31'd0, bus.busy}, 32'd0);
    check("wd_timeout",    {31'd0, bus.timeout}, 32'd1);
    tick();
    check("wd_timeout_sticky", {31'd0, bus.timeout}, 32'd1);
`else
    check("wd_busy_after", {31'd0, bus.busy}, 32'd1);
    check("wd_timeout",    {31'd0, bus.timeout}, 32'd0);
    repeat (40) tick();
    check("wd_still_busy", {31'd0, bus.busy}, 32'd1);
    bus.cpu_done = 1'b1; tick(); bus.cpu_done = 1'b0;
    check("wd_done_idle", {31'd0, bus.busy}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
